bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
Reader-side companion to the team's synchronous memory blocks (register file, BRAM, SRAM).
- A start command supplies a base address and a word count.
- The block issues sequential reads on a 1-cycle-latency synchronous memory port.
- It re-presents the returned words as a valid/ready stream with a last flag.
- Full throughput (one word per cycle) is sustained under continuous ready.
- Under backpressure, read issue is throttled so no returned word is ever lost.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, memory/stream data width
LEN_W, 9, width of the length field (max burst 2^LEN_W-1 words)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe; accepted only in IDLE
start_addr  in  ADDR_W  first word address
length  in  LEN_W  words to read; 0 legal
busy  out  1  high while a burst is in progress (state != IDLE)
done  out  1  one-cycle pulse at burst completion
mem_en  out  1  read enable to memory
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en
out_valid  out  1  stream data valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  stream data
out_last  out  1  marks final word of burst

Behaviour:
- Interface (decided): one clock, clk. rst is asynchronous and active-high.
- Reset: on rst assertion, immediately and without a clock edge: state=IDLE, buffer empty, in-flight cleared. All outputs 0: busy, done, mem_en, mem_addr, out_valid, out_data, out_last.
- Reset mid-burst abandons the burst. No done pulse is produced.
- States:
  - IDLE: on start with length!=0, latch addr/length, go to READ.
  - IDLE: on start with length==0, stay in IDLE and pulse done next cycle. No mem_en, no out_valid, busy never asserts.
  - READ: issue reads. After the read of the final word is issued, go to DRAIN.
  - DRAIN: wait for the last handshake, then go to IDLE.
- start is ignored when state != IDLE.
- start is accepted in the same cycle done is high.
- Issue rule: mem_en = (state==READ) && (occ + inflight - pop < 2).
  - occ: 2-entry output buffer occupancy.
  - inflight: 1 if mem_en was asserted last cycle.
  - pop: out_valid && out_ready.
  - This guarantees occ never exceeds 2.
- mem_addr increments by 1 per issued read and wraps from 2^ADDR_W-1 to 0.
- Capture: mem_rdata is written into the buffer on the edge ending the cycle after mem_en.
- Stream output:
  - out_valid = occ != 0; out_data is the buffer head.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_last is high only for the length-th word. A down-counter of remaining outputs reaches 1 on that word.
- Latency: start accepted in cycle t gives mem_en in t+1 and out_valid in t+3. With out_ready held high, one word per cycle follows thereafter.
- Completion:
  - The handshake on the out_last word moves the state to IDLE.
  - done is high in the following cycle; busy is 0 in that same cycle.
- Simultaneous push and pop on the buffer: occ is unchanged and order is preserved.

Decomposition:
- Shared memory package:
  - state encoding typedef (IDLE, READ, DRAIN).
  - default ADDR_W/DATA_W/LEN_W constants.
- One sub-module: stream_skid_buf, a 2-entry FIFO.
  - Data: DATA_W + 1 bits, the extra bit carrying last.
  - Ports: push/pop/occ, async active-high rst.
- The FSM, address counter, length counters and issue logic stay in the top module.

Test Plan:
- Basic burst: memory model rdata = addr ^ 8'hA5. start_addr=8'h10, length=4, out_ready=1.
  -> mem_en in cycles t+1..t+4.
  -> out_data B5,B4,B7,B6 in t+3..t+6, out_last only on B6.
  -> done=1 at t+7, busy=0 at t+7.
- Backpressure: length=8, out_ready pattern 1,0,0,1,0,1,1,0 repeating.
  -> all 8 words delivered in order, none dropped or duplicated.
  -> occ never exceeds 2; out_data stable while stalled.
- Wrap: start_addr=8'hFE, length=4.
  -> mem_addr sequence FE, FF, 00, 01; out_last on the word from 01.
- Zero length: start with length=0.
  -> done=1 next cycle; mem_en, out_valid and busy stay 0 throughout.
- Start while busy: second start with start_addr=8'h40 mid-burst.
  -> ignored; the original burst completes unchanged.
  -> a start in the done cycle is accepted.
- Async reset: assert rst between clock edges during READ with a full buffer.
  -> all outputs 0 immediately, no done.
  -> after release, a new length=2 burst runs correctly.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: state encoding and default widths.
package bram_stream_reader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_stream_reader_skid_buf.sv
// Two-entry FIFO that holds returned memory words (plus a last flag) until the
// downstream consumer accepts them. Simultaneous push and pop keep order and occupancy.
module stream_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of sequential words from a 1-cycle-latency synchronous memory and
// re-presents them as a valid/ready stream with a last flag, throttling reads under backpressure.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // Stream handshake: a word transfers in any cycle where out_valid && out_ready.
  // Once out_valid is high, out_data/out_last hold until that transfer happens.

  state_t            state;
  state_t            state_nxt;
  logic              done_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_left;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;
  logic [2:0]        level;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic              accept;

  stream_skid_buf #(.W(DATA_W + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_rdata}),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign out_valid = (occ != 2'd0);
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = out_valid && head[DATA_W];
  assign pop       = out_valid && out_ready;

  // Words already buffered or on their way back, minus the one leaving now,
  // must leave room for the read we are about to issue.
  assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ST_READ) && (level < 3'd2);
  assign issue_last = issue && (issue_left == LEN_W'(1));
  assign accept     = (state == ST_IDLE) && start && (length != '0);

  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) state_nxt = ST_READ;
          else              done_nxt  = 1'b1;
        end
      end
      ST_READ: begin
        if (issue_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= start_addr;
        issue_left <= length;
      end else if (issue) begin
        addr_q     <= addr_q + ADDR_W'(1);
        issue_left <= issue_left - LEN_W'(1);
      end
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with an expected-word queue checked by a stream monitor.
module tb_bram_stream_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            rmode = 0;
  bit            pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
  int            pidx = 0;

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // clock / reset, memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_addr ^ 8'hA5;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic issue_start(input logic [AW-1:0] a, input logic [LW-1:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    @(posedge clk);
    #1;
    start  = 1'b0;
    length = '0;
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          out_ready = pat[pidx];
          pidx = (pidx + 1) % 8;
        end
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    bit          stall_prev;
    logic [DW:0] prev_word;
    stall_prev = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (mem_en) begin
          if (exp_addr_q.size() == 0) check("unexpected_mem_en", 32'(mem_addr), 32'hFFFF);
          else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (stall_prev)
          check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", {out_last, out_data}, 32'hFFFF);
          else check("out_word", {out_last, out_data}, 32'(exp_q.pop_front()));
        end
        check("occ_le_2", 32'(dut.occ <= 2'd2), 32'd1);
        stall_prev = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    #2;
    check("reset_outputs", {busy, done, mem_en, mem_addr, out_valid, out_data, out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // basic burst with exact cycle timing
    exp_addr_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    push_word(8'hB5, 0); push_word(8'hB4, 0); push_word(8'hB7, 0); push_word(8'hB6, 1);
    issue_start(8'h10, 9'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("basic_mem_en_c%0d", k), 32'(mem_en), 32'(k <= 4));
      check($sformatf("basic_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 6));
      check($sformatf("basic_done_c%0d", k), 32'(done), 32'(k == 7));
      check($sformatf("basic_busy_c%0d", k), 32'(busy), 32'(k <= 6));
    end
    @(posedge clk); #1;

    // backpressure
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(8'(8'h20 + i));
      push_word(8'(8'h20 + i) ^ 8'hA5, i == 7);
    end
    rmode = 1;
    issue_start(8'h20, 9'd8);
    wait_done("bp_done", 200);
    check("bp_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rmode = 0;

    // address wrap
    exp_addr_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    push_word(8'h5B, 0); push_word(8'h5A, 0); push_word(8'hA5, 0); push_word(8'hA4, 1);
    issue_start(8'hFE, 9'd4);
    wait_done("wrap_done", 50);
    @(posedge clk); #1;

    // zero length
    issue_start(8'h80, 9'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("zero_done_c%0d", k), 32'(done), 32'(k == 1));
      check($sformatf("zero_quiet_c%0d", k), {busy, mem_en, out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // start while busy is ignored; start in the done cycle is accepted
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(8'(8'h30 + i));
      push_word(8'(8'h30 + i) ^ 8'hA5, i == 5);
    end
    issue_start(8'h30, 9'd6);
    issue_start(8'h40, 9'd3);
    wait_done("busy_done", 100);
    #1;
    exp_addr_q.push_back(8'h50); exp_addr_q.push_back(8'h51);
    push_word(8'hF5, 0); push_word(8'hF4, 1);
    issue_start(8'h50, 9'd2);
    check("done_cycle_start_busy", 32'(busy), 32'd1);
    wait_done("done_cycle_start_done", 50);
    @(posedge clk); #1;

    // async reset mid-burst with a full buffer
    rmode = 2;
    repeat (2) @(posedge clk);
    #1;
    exp_addr_q = '{8'h60, 8'h61};
    issue_start(8'h60, 9'd8);
    repeat (4) @(posedge clk);
    #2;
    check("occ_full_before_rst", 32'(dut.occ), 32'd2);
    check("busy_before_rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_outputs", {busy, done, mem_en, mem_addr, out_valid, out_data, out_last}, 32'd0);
    check("rst_addr_q_consumed", 32'(exp_addr_q.size()), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_done_c%0d", k), {done, busy}, 32'd0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    rmode = 0;
    @(posedge clk); #1;
    exp_addr_q = '{8'h70, 8'h71};
    push_word(8'hD5, 0); push_word(8'hD4, 1);
    issue_start(8'h70, 9'd2);
    wait_done("post_rst_done", 50);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
